// File: rtl/adc_rate_pkg.sv
// Shared types and constants for the ADC rate-changer startup/recovery sequencer.
package adc_rate_pkg;

  localparam int unsigned CTRL_CNT_W = 16;
  localparam int unsigned RETRY_W    = 4;
  localparam int unsigned CAUSE_W    = 2;
  localparam int unsigned STAT_W     = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DCM_RST   = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_FIFO_RST  = 3'd3,
    ST_FILL      = 3'd4,
    ST_RUN       = 3'd5,
    ST_FAULT     = 3'd6,
    ST_FAILED    = 3'd7
  } adc_ctrl_state_t;

  localparam logic [CAUSE_W-1:0] FC_NONE         = 2'd0;
  localparam logic [CAUSE_W-1:0] FC_LOCK_TIMEOUT = 2'd1;
  localparam logic [CAUSE_W-1:0] FC_LOCK_LOSS    = 2'd2;
  localparam logic [CAUSE_W-1:0] FC_FIFO         = 2'd3;

endpackage

// File: rtl/adc_sync2.sv
// Generic two-flop synchronizer, async active-low reset to 0.
module adc_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/adc_rate_ctrl.sv
// Startup/recovery sequencer for the DCM, 320 MHz mux and CDC FIFO (clkin320 domain).
// Define ADC_RATE_CTRL_STATS_EN to add RUN-state fault event counters.
module adc_rate_ctrl
  import adc_rate_pkg::*;
#(
  parameter int unsigned RST_CYCLES      = 16,
  parameter int unsigned LOCK_TIMEOUT    = 4096,
  parameter int unsigned FIFO_RST_CYCLES = 8,
  parameter int unsigned FILL_CYCLES     = 32,
  parameter int unsigned MAX_RETRY       = 3
) (
  input  logic                  clkin320,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  restart,
  input  logic                  dcm_locked,
  input  logic                  fifo_empty,
  input  logic                  fifo_full,
  output logic                  dcm_reset,
  output logic                  fifo_rst,
  output logic                  data_valid,
  output logic [2:0]            state,
  output logic [CAUSE_W-1:0]    fault_cause,
  output logic [RETRY_W-1:0]    retry_cnt,
  output logic                  failed
`ifdef ADC_RATE_CTRL_STATS_EN
  ,
  output logic [STAT_W-1:0]     underflow_cnt,
  output logic [STAT_W-1:0]     overflow_cnt,
  output logic [STAT_W-1:0]     lock_loss_cnt
`endif
);

  localparam logic [CTRL_CNT_W-1:0] RST_LOAD  = CTRL_CNT_W'(RST_CYCLES - 1);
  localparam logic [CTRL_CNT_W-1:0] LOCK_LOAD = CTRL_CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CTRL_CNT_W-1:0] FRST_LOAD = CTRL_CNT_W'(FIFO_RST_CYCLES - 1);
  localparam logic [CTRL_CNT_W-1:0] FILL_LOAD = CTRL_CNT_W'(FILL_CYCLES - 1);
  localparam logic [RETRY_W-1:0]    RETRY_LIMIT = RETRY_W'(MAX_RETRY);
  localparam logic [RETRY_W-1:0]    RETRY_SAT   = '1;

  logic                  lock_s;
  adc_ctrl_state_t       state_q, state_d;
  logic [CTRL_CNT_W-1:0] cnt_q, cnt_d;
  logic [RETRY_W-1:0]    retry_d;
  logic [CAUSE_W-1:0]    cause_d;
  logic                  fault_hit;
  logic                  dcm_reset_d, fifo_rst_d, data_valid_d, failed_d;

  adc_sync2 u_lock_sync (
    .clk   (clkin320),
    .rst_n (reset_n),
    .d     (dcm_locked),
    .q     (lock_s)
  );

  // State, phase counter and registered outputs
  always_ff @(posedge clkin320 or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      retry_cnt   <= '0;
      fault_cause <= FC_NONE;
      dcm_reset   <= 1'b1;
      fifo_rst    <= 1'b1;
      data_valid  <= 1'b0;
      failed      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_cnt   <= retry_d;
      fault_cause <= cause_d;
      dcm_reset   <= dcm_reset_d;
      fifo_rst    <= fifo_rst_d;
      data_valid  <= data_valid_d;
      failed      <= failed_d;
    end
  end

  assign state = state_q;

  // Next state: enable, then restart, then faults, then normal sequencing
  always_comb begin
    state_d   = state_q;
    cnt_d     = (cnt_q != '0) ? cnt_q - CTRL_CNT_W'(1) : cnt_q;
    retry_d   = retry_cnt;
    cause_d   = fault_cause;
    fault_hit = 1'b0;

    if (!enable) begin
      state_d = ST_IDLE;
      retry_d = '0;
    end else if (restart) begin
      state_d = ST_DCM_RST;
      cnt_d   = RST_LOAD;
      retry_d = '0;
      cause_d = FC_NONE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_DCM_RST;
          cnt_d   = RST_LOAD;
        end
        ST_DCM_RST: begin
          if (cnt_q == '0) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = LOCK_LOAD;
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_d = ST_FIFO_RST;
            cnt_d   = FRST_LOAD;
          end else if (cnt_q == '0) begin
            fault_hit = 1'b1;
            cause_d   = FC_LOCK_TIMEOUT;
          end
        end
        ST_FIFO_RST: begin
          if (!lock_s) begin
            fault_hit = 1'b1;
            cause_d   = FC_LOCK_LOSS;
          end else if (cnt_q == '0) begin
            state_d = ST_FILL;
            cnt_d   = FILL_LOAD;
          end
        end
        ST_FILL: begin
          if (!lock_s) begin
            fault_hit = 1'b1;
            cause_d   = FC_LOCK_LOSS;
          end else if (fifo_empty) begin
            cnt_d = FILL_LOAD;
          end else if (cnt_q == '0) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            fault_hit = 1'b1;
            cause_d   = FC_LOCK_LOSS;
          end else if (fifo_empty || fifo_full) begin
            fault_hit = 1'b1;
            cause_d   = FC_FIFO;
          end
        end
        ST_FAULT: begin
          if (retry_cnt >= RETRY_LIMIT) begin
            state_d = ST_FAILED;
          end else begin
            state_d = ST_DCM_RST;
            cnt_d   = RST_LOAD;
          end
        end
        ST_FAILED: begin
          state_d = ST_FAILED;
        end
      endcase

      if (fault_hit) begin
        state_d = ST_FAULT;
        retry_d = (retry_cnt == RETRY_SAT) ? RETRY_SAT : retry_cnt + RETRY_W'(1);
      end
    end
  end

  // Output decode from the upcoming state so outputs track state_q exactly
  always_comb begin
    dcm_reset_d  = 1'b0;
    fifo_rst_d   = 1'b0;
    data_valid_d = 1'b0;
    failed_d     = 1'b0;
    case (state_d)
      ST_IDLE, ST_DCM_RST, ST_FAULT: begin
        dcm_reset_d = 1'b1;
        fifo_rst_d  = 1'b1;
      end
      ST_WAIT_LOCK, ST_FIFO_RST: begin
        fifo_rst_d = 1'b1;
      end
      ST_FILL: begin
        fifo_rst_d = 1'b0;
      end
      ST_RUN: begin
        data_valid_d = 1'b1;
      end
      ST_FAILED: begin
        dcm_reset_d = 1'b1;
        fifo_rst_d  = 1'b1;
        failed_d    = 1'b1;
      end
    endcase
  end

`ifdef ADC_RATE_CTRL_STATS_EN
  logic run_chk;
  assign run_chk = (state_q == ST_RUN) && enable && !restart;

  // RUN-state fault event counters; lock loss outranks FIFO, underflow outranks overflow
  always_ff @(posedge clkin320 or negedge reset_n) begin
    if (!reset_n) begin
      underflow_cnt <= '0;
      overflow_cnt  <= '0;
      lock_loss_cnt <= '0;
    end else if (restart) begin
      underflow_cnt <= '0;
      overflow_cnt  <= '0;
      lock_loss_cnt <= '0;
    end else if (run_chk) begin
      if (!lock_s) begin
        if (lock_loss_cnt != '1) lock_loss_cnt <= lock_loss_cnt + STAT_W'(1);
      end else if (fifo_empty) begin
        if (underflow_cnt != '1) underflow_cnt <= underflow_cnt + STAT_W'(1);
      end else if (fifo_full) begin
        if (overflow_cnt != '1) overflow_cnt <= overflow_cnt + STAT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_adc_rate_ctrl.sv
// Scoreboard bench for adc_rate_ctrl: a phase-timing model predicts every state
// transition; a monitor pops and checks each one as the DUT state changes.
module tb_adc_rate_ctrl;

  localparam int R    = 16;
  localparam int T    = 64;
  localparam int F    = 8;
  localparam int FL   = 32;
  localparam int MR   = 3;
  localparam int MAXN = 1024;

  localparam int S_IDLE = 0, S_DRST = 1, S_WAIT = 2, S_FRST = 3;
  localparam int S_FILL = 4, S_RUN = 5, S_FAULT = 6, S_FAILED = 7;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0, restart = 1'b0, dcm_locked = 1'b0;
  logic fifo_empty = 1'b1, fifo_full = 1'b0;
  logic dcm_reset, fifo_rst, data_valid, failed;
  logic [2:0] state;
  logic [1:0] fault_cause;
  logic [3:0] retry_cnt;
`ifdef ADC_RATE_CTRL_STATS_EN
  logic [15:0] underflow_cnt, overflow_cnt, lock_loss_cnt;
`endif

  adc_rate_ctrl #(
    .RST_CYCLES(R), .LOCK_TIMEOUT(T), .FIFO_RST_CYCLES(F),
    .FILL_CYCLES(FL), .MAX_RETRY(MR)
  ) dut (
    .clkin320(clk), .reset_n(reset_n), .enable(enable), .restart(restart),
    .dcm_locked(dcm_locked), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .dcm_reset(dcm_reset), .fifo_rst(fifo_rst), .data_valid(data_valid),
    .state(state), .fault_cause(fault_cause), .retry_cnt(retry_cnt), .failed(failed)
`ifdef ADC_RATE_CTRL_STATS_EN
    , .underflow_cnt(underflow_cnt), .overflow_cnt(overflow_cnt), .lock_loss_cnt(lock_loss_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Input plan, one entry per rising edge (value sampled at that edge)
  logic a_en[MAXN], a_rs[MAXN], a_lk[MAXN], a_em[MAXN], a_fu[MAXN];

  typedef struct {
    int         at;
    logic [2:0] st;
    logic [1:0] cause;
    logic [3:0] retry;
    logic       fl, dr, fr, dv;
  } exp_t;

  exp_t q[$];
  exp_t e_m;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cur_edge = 0;
  bit   mon_en = 1'b0;
  logic [2:0] prev_st = 3'd0;

  // Lock as seen by the controller at edge k: raw lock two edges earlier
  function automatic logic lks(input int k);
    return (k >= 2) ? a_lk[k-2] : 1'b0;
  endfunction

  task automatic push_exp(input int at, input int st, input int cause, input int retry);
    exp_t e;
    e.at    = at;
    e.st    = 3'(st);
    e.cause = 2'(cause);
    e.retry = 4'(retry);
    e.fl    = (st == S_FAILED);
    e.dr    = (st == S_IDLE || st == S_DRST || st == S_FAULT || st == S_FAILED);
    e.fr    = e.dr || st == S_WAIT || st == S_FRST;
    e.dv    = (st == S_RUN);
    q.push_back(e);
  endtask

  // Phase model: each phase lasts a fixed time since entry unless an event cuts it short
  task automatic model(input int n);
    int st, nst, entry, p, retry, cause;
    bit fault, reenter;
    st = S_IDLE; entry = 0; p = 0; retry = 0; cause = 0;
    for (int j = 0; j < n; j++) begin
      nst = st; fault = 0; reenter = 0;
      if (!a_en[j]) begin
        nst = S_IDLE; retry = 0;
      end else if (a_rs[j]) begin
        nst = S_DRST; retry = 0; cause = 0; reenter = 1;
      end else begin
        case (st)
          S_IDLE:   nst = S_DRST;
          S_DRST:   if (j - entry == R) nst = S_WAIT;
          S_WAIT:   if (lks(j)) nst = S_FRST;
                    else if (j - entry == T) begin fault = 1; cause = 1; end
          S_FRST:   if (!lks(j)) begin fault = 1; cause = 2; end
                    else if (j - entry == F) nst = S_FILL;
          S_FILL:   if (!lks(j)) begin fault = 1; cause = 2; end
                    else if (a_em[j]) p = j;
                    else if (j - p == FL) nst = S_RUN;
          S_RUN:    if (!lks(j)) begin fault = 1; cause = 2; end
                    else if (a_em[j] || a_fu[j]) begin fault = 1; cause = 3; end
          S_FAULT:  nst = (retry >= MR) ? S_FAILED : S_DRST;
          default:  nst = st;
        endcase
        if (fault) begin
          nst = S_FAULT;
          retry = (retry >= 15) ? 15 : retry + 1;
        end
      end
      if (nst != st || reenter) begin
        entry = j;
        p = j;
      end
      if (nst != st) push_exp(j, nst, cause, retry);
      st = nst;
    end
  endtask

  // Monitor: every DUT state change must match the head of the expectation queue
  always @(negedge clk) begin
    if (mon_en && state !== prev_st) begin
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_transition edge=%0d state=%0d, required no transition", cur_edge, state);
      end else begin
        e_m = q.pop_front();
        if (e_m.at != cur_edge || state !== e_m.st || fault_cause !== e_m.cause ||
            retry_cnt !== e_m.retry || failed !== e_m.fl || dcm_reset !== e_m.dr ||
            fifo_rst !== e_m.fr || data_valid !== e_m.dv) begin
          n_fail++;
          $display("FAIL transition got edge=%0d st=%0d cause=%0d retry=%0d failed=%0b dr=%0b fr=%0b dv=%0b required edge=%0d st=%0d cause=%0d retry=%0d failed=%0b dr=%0b fr=%0b dv=%0b",
                   cur_edge, state, fault_cause, retry_cnt, failed, dcm_reset, fifo_rst, data_valid,
                   e_m.at, e_m.st, e_m.cause, e_m.retry, e_m.fl, e_m.dr, e_m.fr, e_m.dv);
        end
      end
    end
    prev_st = state;
  end

  task automatic check(input string name, input int got, input int req);
    n_tests++;
    if (got != req) begin
      n_fail++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  task automatic clr(input int n);
    for (int k = 0; k < MAXN; k++) begin
      a_en[k] = 1'b1; a_rs[k] = 1'b0; a_lk[k] = 1'b0; a_em[k] = 1'b1; a_fu[k] = 1'b0;
    end
    for (int k = n; k < MAXN; k++) a_en[k] = 1'b0;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    reset_n = 1'b0;
    enable = 1'b0; restart = 1'b0; dcm_locked = 1'b0; fifo_empty = 1'b1; fifo_full = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic play(input string name, input int n);
    q.delete();
    model(n);
    do_reset();
    mon_en = 1'b1;
    for (int k = 0; k < n; k++) begin
      enable = a_en[k]; restart = a_rs[k]; dcm_locked = a_lk[k];
      fifo_empty = a_em[k]; fifo_full = a_fu[k];
      @(posedge clk);
      cur_edge = k;
      #1;
    end
    @(negedge clk);
    #1;
    check({name, "_pending"}, q.size(), 0);
    mon_en = 1'b0;
  endtask

  task automatic gen_random(input int n);
    int l, d, len, e0, k2, x;
    clr(n);
    l = int'($urandom_range(0, 100));
    for (int k = l; k < n; k++) a_lk[k] = 1'b1;
    if ($urandom_range(0, 9) < 4) begin
      d = int'($urandom_range(l + 120, n - 60));
      len = int'($urandom_range(1, 5));
      for (int i = 0; i < len; i++) a_lk[d+i] = 1'b0;
    end
    e0 = int'($urandom_range(l + 10, l + 150));
    for (int k = e0; k < n; k++) a_em[k] = 1'b0;
    k2 = int'($urandom_range(0, 3));
    for (int i = 0; i < k2; i++) begin
      x = int'($urandom_range(e0, n - 1));
      a_em[x] = 1'b1;
    end
    if ($urandom_range(0, 9) < 3) begin
      x = int'($urandom_range(200, n - 1));
      a_fu[x] = 1'b1;
    end
    if ($urandom_range(0, 9) < 2) begin
      x = int'($urandom_range(100, n - 1));
      a_rs[x] = 1'b1;
    end
    if ($urandom_range(0, 9) < 3) begin
      x = int'($urandom_range(300, n - 10));
      for (int i = 0; i < 3; i++) a_en[x+i] = 1'b0;
    end
  endtask

  initial begin
    // Reset values
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_state", int'(state), S_IDLE);
    check("rst_outputs", int'({dcm_reset, fifo_rst, data_valid, failed}), 4'b1100);
    check("rst_cause_retry", int'({fault_cause, retry_cnt}), 0);

    // Nominal bring-up, then enable dropped in RUN and brought back
    clr(270);
    for (int k = 40; k < 270; k++) a_lk[k] = 1'b1;
    for (int k = 80; k < 270; k++) a_em[k] = 1'b0;
    for (int k = 250; k < 260; k++) a_en[k] = 1'b0;
    play("nominal", 270);

    // Lock timeout x3 -> FAILED, restart, then disable
    clr(340);
    a_rs[300] = 1'b1;
    for (int k = 330; k < 340; k++) a_en[k] = 1'b0;
    play("timeout", 340);

    // Underflow in RUN, re-sequence back to RUN
    clr(300);
    for (int k = 40; k < 300; k++) a_lk[k] = 1'b1;
    for (int k = 80; k < 300; k++) a_em[k] = 1'b0;
    a_em[150] = 1'b1;
    play("underflow", 300);
`ifdef ADC_RATE_CTRL_STATS_EN
    check("underflow_cnt", int'(underflow_cnt), 1);
    check("overflow_cnt", int'(overflow_cnt), 0);
`endif

    // Lock loss in RUN
    clr(260);
    for (int k = 40; k < 150; k++) a_lk[k] = 1'b1;
    for (int k = 80; k < 260; k++) a_em[k] = 1'b0;
    play("lock_loss", 260);

    // FILL glitch at FILL cycle 20
    clr(120);
    for (int k = 10; k < 120; k++) a_lk[k] = 1'b1;
    for (int k = 0; k < 120; k++) a_em[k] = 1'b0;
    a_em[45] = 1'b1;
    play("fill_glitch", 120);

    // Randomized scenarios
    for (int s = 0; s < 6; s++) begin
      gen_random(700);
      play("random", 700);
    end

    // Parked in FILL (FIFO never fills), then async reset mid-cycle
    clr(60);
    for (int k = 0; k < 60; k++) a_lk[k] = 1'b1;
    play("fill_park", 60);
    check("fill_park_state", int'(state), S_FILL);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_state", int'(state), S_IDLE);
    check("async_rst_outputs", int'({dcm_reset, fifo_rst, data_valid, failed}), 4'b1100);
    check("async_rst_cause_retry", int'({fault_cause, retry_cnt}), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_rate_ctrl.md
Name: adc_rate_ctrl

Overview:
Startup and recovery sequencer for the ADC rate-changer datapath: DCM, 320 MHz mux and clock-crossing FIFO. Runs in the clkin320 read domain. Pulses the DCM reset, waits for lock, flushes the FIFO and waits for stable fill before flagging output data valid. Monitors underflow, overflow and lock loss, retries a bounded number of times, then latches a failure.

Parameters:
RST_CYCLES, 16, cycles dcm_reset is held high per attempt (1..65535)
LOCK_TIMEOUT, 4096, cycles to wait for synchronized lock before fault (1..65535)
FIFO_RST_CYCLES, 8, cycles fifo_rst is held high after lock (1..65535)
FILL_CYCLES, 32, consecutive non-empty cycles required before RUN (1..65535)
MAX_RETRY, 3, faults tolerated before FAILED (1..15)

Ports:
clkin320  in  1  sole clock; all logic on its rising edge
reset_n  in  1  asynchronous, active-low reset
enable  in  1  level; 1 = bring up and keep datapath running
restart  in  1  single-cycle pulse; forces a fresh bring-up and clears retries
dcm_locked  in  1  DCM lock; asynchronous, double-flop synchronized inside
fifo_empty  in  1  FIFO empty flag, read side
fifo_full  in  1  FIFO full flag; treated as synchronous, sampled as-is
dcm_reset  out  1  DCM reset
fifo_rst  out  1  FIFO reset
data_valid  out  1  1 = i_out/q_out carry valid samples
state  out  3  current state encoding
fault_cause  out  2  last fault: 0 none, 1 lock timeout, 2 lock loss, 3 fifo under/overflow
retry_cnt  out  4  faults since last restart or enable
failed  out  1  sticky; 1 in FAILED

Behaviour:
- All outputs registered. Reset values: dcm_reset=1, fifo_rst=1, data_valid=0, state=IDLE, fault_cause=0, retry_cnt=0, failed=0.
- lock_s = dcm_locked after 2 flops; reset value 0. Lock changes are visible 2 cycles late.
- One 16-bit down-counter cnt is loaded on each state entry.
- Encodings: IDLE=0, DCM_RST=1, WAIT_LOCK=2, FIFO_RST=3, FILL=4, RUN=5, FAULT=6, FAILED=7.
- IDLE: dcm_reset=1, fifo_rst=1. enable=1 -> DCM_RST with cnt=RST_CYCLES-1.
- DCM_RST: dcm_reset=1, fifo_rst=1. cnt==0 -> WAIT_LOCK with cnt=LOCK_TIMEOUT-1. dcm_reset is high for exactly RST_CYCLES cycles.
- WAIT_LOCK: dcm_reset=0, fifo_rst=1.
  - lock_s=1 -> FIFO_RST with cnt=FIFO_RST_CYCLES-1.
  - Otherwise cnt==0 -> FAULT with cause 1.
  - lock_s wins if both occur in the same cycle.
- FIFO_RST: fifo_rst=1. cnt==0 -> FILL with cnt=FILL_CYCLES-1. lock_s=0 -> FAULT with cause 2.
- FILL: fifo_rst=0.
  - fifo_empty=1 reloads cnt=FILL_CYCLES-1.
  - cnt==0 with fifo_empty=0 -> RUN.
  - lock_s=0 -> FAULT with cause 2.
- RUN: data_valid=1.
  - lock_s=0 -> FAULT with cause 2.
  - Else fifo_empty=1 or fifo_full=1 -> FAULT with cause 3.
  - data_valid drops on the same edge that enters FAULT.
- FAULT: one cycle. dcm_reset=1, fifo_rst=1, retry_cnt+1 (saturating at 15).
  - If the new retry_cnt ≥ MAX_RETRY -> FAILED.
  - Else -> DCM_RST with cnt=RST_CYCLES-1.
- FAILED: dcm_reset=1, fifo_rst=1, failed=1. Held until restart or enable=0.
- fault_cause is latched on FAULT entry. It is cleared only by reset or by restart.
- Priority per cycle, highest first:
  1. enable=0: any state -> IDLE; retry_cnt=0; failed=0; fault_cause kept.
  2. restart=1 with enable=1: any state -> DCM_RST; retry_cnt=0; fault_cause=0; failed=0.
  3. Fault conditions.
  4. Normal sequencing.
- Async reset mid-sequence: immediate return to reset values. dcm_reset and fifo_rst assert asynchronously.

Optional Feature:
ADC_RATE_CTRL_STATS_EN
- Defined: adds outputs underflow_cnt[15:0], overflow_cnt[15:0] and lock_loss_cnt[15:0].
  - Each counts RUN-state fault events of its kind.
  - Counters saturate at 16'hFFFF.
  - They clear on reset_n and on restart only; enable=0 does not clear them.
  - If fifo_empty and fifo_full are both 1 in RUN, only underflow_cnt increments.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Decomposition:
- Package adc_rate_pkg holds:
  - state enum typedef adc_ctrl_state_t (3-bit);
  - fault-cause constants FC_NONE, FC_LOCK_TIMEOUT, FC_LOCK_LOSS, FC_FIFO;
  - counter width constant CTRL_CNT_W=16.
- One sub-module, adc_sync2: generic two-flop synchronizer with async active-low reset to 0. Used for dcm_locked.

Test Plan:
1. Nominal bring-up: enable=1, dcm_locked rises at cycle 40, fifo_empty=0 from cycle 80 -> dcm_reset high cycles 1–16; fifo_rst high 8 cycles after lock_s; data_valid=1 after 32 non-empty FILL cycles; state=5.
2. Lock timeout: LOCK_TIMEOUT=64, dcm_locked held 0 -> FAULT after 64 WAIT_LOCK cycles; fault_cause=1; retries 1,2,3 -> FAILED, failed=1, dcm_reset=1.
3. Underflow in RUN: fifo_empty pulsed 1 cycle -> data_valid=0 next edge; fault_cause=3; retry_cnt=1; re-sequence to RUN. With STATS_EN, underflow_cnt=1.
4. Lock loss in RUN: dcm_locked drops -> FAULT 2 cycles later (synchronizer latency); fault_cause=2.
5. FILL glitch: fifo_empty=1 at FILL cycle 20 -> counter reloads; RUN entered 32 cycles after the last empty.
6. Controls: restart in FAILED -> DCM_RST, retry_cnt=0, failed=0. enable=0 in RUN -> IDLE next cycle, data_valid=0. reset_n low mid-FILL -> reset values asynchronously.
